// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_pkg
// Description : Opcodes, FSM states and status-flag layout shared by alu_mc.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

    typedef enum logic [4:0] {
        OP_INC = 5'b00001, OP_DEC = 5'b00011, OP_ADD = 5'b00100, OP_ADC = 5'b00101,
        OP_SUB = 5'b00110, OP_SBB = 5'b00111, OP_AND = 5'b01000, OP_OR  = 5'b01001,
        OP_XOR = 5'b01010, OP_NOT = 5'b01011, OP_SHL = 5'b10000, OP_SHR = 5'b10001,
        OP_SAL = 5'b10010, OP_SAR = 5'b10011, OP_ROL = 5'b10100, OP_ROR = 5'b10101,
        OP_RCL = 5'b10110, OP_RCR = 5'b10111, OP_MUL = 5'b11000, OP_DIV = 5'b11001
    } alu_op_e;

`ifdef ALU_MC_MULDIV_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} alu_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} alu_state_e;
`endif

    localparam int FLAG_C = 5;
    localparam int FLAG_Z = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_P = 1;
    localparam int FLAG_A = 0;

    function automatic logic [5:0] pack_flags(input logic c, input logic z, input logic n,
                                              input logic v, input logic p, input logic a);
        logic [5:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_P] = p;
        f[FLAG_A] = a;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc_iter
// Description : Shift-add multiply / restoring divide, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic             is_div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   mul_sum, div_trial;

    // hi holds partial product / partial remainder; lo holds multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opd_q};
        if (is_div_q) begin
            hi_d = div_trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : div_trial[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div_i;
            cnt_q    <= CW'(WIDTH - 1);
            hi_q     <= '0;
            lo_q     <= is_div_i ? a_i : b_i;
            opd_q    <= is_div_i ? b_i : a_i;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The final step's value is handed over combinationally so the top can
    // register it on the same edge the last iteration completes.
    assign done_o = busy_q && (cnt_q == '0);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshake and status register.
//               Define ALU_MC_MULDIV_EN to build the MUL/DIV iteration engine.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [5:0]       status,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic [5:0]       status_q;
    logic             err_q;

    logic [WIDTH-1:0] opb, sc_res;
    logic             cin, sc_c, sc_v, sc_af, sc_legal, sc_err;
    logic [WIDTH:0]   sum, diff;
    logic [4:0]       nsum, ndiff;
    logic [5:0]       sc_status;
    logic             iter_start;

    assign opb   = (op == OP_INC || op == OP_DEC) ? ONE : b;
    assign cin   = (op == OP_ADC || op == OP_SBB) ? status_q[FLAG_C] : 1'b0;
    assign sum   = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    assign diff  = {1'b0, a} - {1'b0, opb} - {{WIDTH{1'b0}}, cin};
    assign nsum  = {1'b0, a[3:0]} + {1'b0, opb[3:0]} + {4'b0, cin};
    assign ndiff = {1'b0, a[3:0]} - {1'b0, opb[3:0]} - {4'b0, cin};

`ifdef ALU_MC_MULDIV_EN
    logic [WIDTH-1:0] sc_hi, hi_q, it_lo, it_hi;
    logic             it_done, div_q, it_hnz;
`endif

    always_comb begin
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_af    = 1'b0;
        sc_legal = 1'b1;
        sc_err   = 1'b0;
`ifdef ALU_MC_MULDIV_EN
        sc_hi    = '0;
`endif
        case (op)
            OP_INC, OP_ADD, OP_ADC: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                sc_af  = nsum[4];
            end
            OP_DEC, OP_SUB, OP_SBB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
                sc_v   = (a[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                sc_af  = ndiff[4];
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_NOT: sc_res = ~a;
            OP_SHL, OP_SAL: begin
                sc_res = {a[WIDTH-2:0], 1'b0};
                sc_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_SAR: begin
                sc_res = {a[WIDTH-1], a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_ROL: begin
                sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
                sc_c   = a[WIDTH-1];
            end
            OP_ROR: begin
                sc_res = {a[0], a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_RCL: begin
                sc_res = {a[WIDTH-2:0], status_q[FLAG_C]};
                sc_c   = a[WIDTH-1];
            end
            OP_RCR: begin
                sc_res = {status_q[FLAG_C], a[WIDTH-1:1]};
                sc_c   = a[0];
            end
`ifdef ALU_MC_MULDIV_EN
            OP_MUL: sc_res = '0;
            OP_DIV: begin
                // Only divide-by-zero completes here; real divides iterate.
                if (b == '0) begin
                    sc_res = '1;
                    sc_hi  = a;
                    sc_v   = 1'b1;
                    sc_err = 1'b1;
                end
            end
`endif
            default: begin
                sc_legal = 1'b0;
                sc_err   = 1'b1;
            end
        endcase
    end

    assign sc_status = pack_flags(sc_c, ~|sc_res, sc_res[WIDTH-1], sc_v, ~^sc_res, sc_af);

`ifdef ALU_MC_MULDIV_EN
    assign iter_start = (state_q == ST_IDLE) && in_valid &&
                        ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
    assign it_hnz     = |it_hi;

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (iter_start),
        .is_div_i (op == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .done_o   (it_done),
        .lo_o     (it_lo),
        .hi_o     (it_hi)
    );
`else
    assign iter_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            hi_q     <= '0;
            div_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!iter_start) begin
                            state_q  <= ST_DONE;
                            result_q <= sc_res;
                            err_q    <= sc_err;
                            if (sc_legal) begin
                                status_q <= sc_status;
                            end
`ifdef ALU_MC_MULDIV_EN
                            hi_q     <= sc_hi;
`endif
                        end
`ifdef ALU_MC_MULDIV_EN
                        else begin
                            state_q <= ST_EXEC;
                        end
                        div_q <= (op == OP_DIV);
`endif
                    end
                end
`ifdef ALU_MC_MULDIV_EN
                ST_EXEC: begin
                    if (it_done) begin
                        state_q  <= ST_DONE;
                        result_q <= it_lo;
                        hi_q     <= it_hi;
                        err_q    <= 1'b0;
                        status_q <= pack_flags(!div_q && it_hnz, ~|it_lo, it_lo[WIDTH-1],
                                               !div_q && it_hnz, ~^it_lo, 1'b0);
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign status    = status_q;
    assign err       = err_q;
`ifdef ALU_MC_MULDIV_EN
    assign hi        = hi_q;
`else
    assign hi        = '0;
`endif

endmodule
`default_nettype wire
